// File: rtl/gf_pkg.sv
// Galois-field helpers shared by the Reed-Solomon syndrome datapath.
// Holds the default field parameters and the elaboration-time arithmetic
// used to derive constant multipliers:
//   gf_mul(a, b, m, poly)     -> a * b in GF(2^m), reduced by x^m + poly
//   gf_alpha_pow(k, m, poly)  -> alpha^k, alpha = x, any integer k
package gf_pkg;

    localparam int         GF_M_DEF         = 5;
    localparam logic [4:0] GF_PRIM_POLY_DEF = 5'h05;

    // Shift-and-add multiply; poly carries only the low m bits of the primitive polynomial.
    function automatic logic [31:0] gf_mul(
        input logic [31:0] a,
        input logic [31:0] b,
        input int          m,
        input logic [31:0] poly
    );
        logic [31:0] p;
        logic [31:0] x;
        p = 32'd0;
        x = a;
        for (int i = 0; i < m; i++) begin
            if (b[i]) begin
                p = p ^ x;
            end else begin
                p = p;
            end
            x = x << 1;
            // Fold x^m back into the field using x^m = poly.
            if (x[m]) begin
                x = x ^ poly ^ (32'd1 << m);
            end else begin
                x = x;
            end
        end
        return p;
    endfunction

    // Negative exponents wrap into [0, 2^m-2], so alpha^-1 is gf_alpha_pow(-1, ...).
    function automatic logic [31:0] gf_alpha_pow(
        input int          k,
        input int          m,
        input logic [31:0] poly
    );
        logic [31:0] r;
        int          order;
        int          e;
        order = int'((32'd1 << m) - 32'd1);
        e     = k % order;
        if (e < 0) begin
            e = e + order;
        end else begin
            e = e;
        end
        r = 32'd1;
        for (int i = 0; i < e; i++) begin
            r = gf_mul(r, 32'd2, m, poly);
        end
        return r;
    endfunction

endpackage

// File: rtl/gf_mul_const.sv
// Combinational multiply of a field element by the constant alpha^K.
// The constant is fixed at elaboration, so the product collapses to an
// XOR network of op_i bits.
//   op_i   [M-1:0]  operand
//   prod_o [M-1:0]  op_i * alpha^K in GF(2^M)
module gf_mul_const
    import gf_pkg::*;
#(
    parameter int         M         = GF_M_DEF,
    parameter logic [M-1:0] PRIM_POLY = GF_PRIM_POLY_DEF,
    parameter int         K         = 1
) (
    input  logic [M-1:0] op_i,
    output logic [M-1:0] prod_o
);

    localparam logic [31:0] POLY32 = 32'(PRIM_POLY);
    localparam logic [31:0] COEF   = gf_alpha_pow(K, M, POLY32);

    // Constant-coefficient product; only op_i varies.
    always_comb begin
        prod_o = M'(gf_mul(32'(op_i), COEF, M, POLY32));
    end

endmodule

// File: rtl/rs_syndrome_serial.sv
// Streaming Reed-Solomon syndrome calculator over GF(2^M).
// One symbol per transfer, highest-order first; NSYN Horner accumulators
// evaluate the codeword at alpha^(FCR+j). Completed syndromes sit in a single
// output register handed downstream with valid/ready.
//   clk, rstn            clock, async active-low reset
//   in_valid/in_ready    input symbol handshake, in_sym symbol, in_sop first-symbol marker
//   out_valid/out_ready  syndrome handshake, out_syn packed S_j, out_err any syndrome nonzero
//   abort                one-cycle pulse when in_sop restarts an unfinished codeword
module rs_syndrome_serial
    import gf_pkg::*;
#(
    parameter int           M         = GF_M_DEF,
    parameter int           N         = 31,
    parameter int           NSYN      = 2,
    parameter int           FCR       = 1,
    parameter logic [M-1:0] PRIM_POLY = GF_PRIM_POLY_DEF
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [M-1:0]      in_sym,
    input  logic              in_sop,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [NSYN*M-1:0] out_syn,
    output logic              out_err,
    output logic              abort
);

    if (N < 2 || N > (2 ** M) - 1) begin : g_bad_n
        $error("rs_syndrome_serial: N must satisfy 2 <= N <= 2^M-1");
    end

    localparam int            CW       = $clog2(N + 1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    logic [CW-1:0]      count_q,     count_d;
    logic [NSYN*M-1:0]  acc_q,       acc_d;
    logic               out_valid_q, out_valid_d;
    logic [NSYN*M-1:0]  out_syn_q,   out_syn_d;
    logic               out_err_q,   out_err_d;
    logic               abort_q,     abort_d;

    logic [NSYN*M-1:0]  mul_s;
    logic [NSYN*M-1:0]  acc_upd_s;
    logic               in_ready_s;
    logic               xfer_s;
    logic               first_s;
    logic               done_s;

    for (genvar j = 0; j < NSYN; j++) begin : g_root
        gf_mul_const #(
            .M         (M),
            .PRIM_POLY (PRIM_POLY),
            .K         (FCR + j)
        ) u_mul (
            .op_i   (acc_q[j*M +: M]),
            .prod_o (mul_s[j*M +: M])
        );
    end

    // Handshake, Horner step, completion detection and next-state selection.
    always_comb begin
        in_ready_s = !out_valid_q || out_ready;
        xfer_s     = in_valid && in_ready_s;
        // Any in_sop restarts; an idle counter starts a codeword implicitly.
        first_s    = in_sop || (count_q == CNT_ZERO);
        for (int j = 0; j < NSYN; j++) begin
            acc_upd_s[j*M +: M] = (first_s ? {M{1'b0}} : mul_s[j*M +: M]) ^ in_sym;
        end
        // N >= 2, so a restarting symbol can never also be the last one.
        done_s = xfer_s && !first_s && (count_q == CNT_LAST);

        count_d     = count_q;
        acc_d       = acc_q;
        out_valid_d = out_valid_q;
        out_syn_d   = out_syn_q;
        out_err_d   = out_err_q;
        abort_d     = 1'b0;

        if (xfer_s) begin
            acc_d   = acc_upd_s;
            abort_d = in_sop && (count_q != CNT_ZERO);
            if (done_s) begin
                count_d = CNT_ZERO;
            end else if (first_s) begin
                count_d = CNT_ONE;
            end else begin
                count_d = count_q + CNT_ONE;
            end
        end else begin
            acc_d   = acc_q;
            abort_d = 1'b0;
        end

        // A completion overrides the drain, keeping back-to-back results bubble-free.
        if (done_s) begin
            out_valid_d = 1'b1;
            out_syn_d   = acc_upd_s;
            out_err_d   = |acc_upd_s;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count_q     <= CNT_ZERO;
            acc_q       <= {(NSYN*M){1'b0}};
            out_valid_q <= 1'b0;
            out_syn_q   <= {(NSYN*M){1'b0}};
            out_err_q   <= 1'b0;
            abort_q     <= 1'b0;
        end else begin
            count_q     <= count_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            out_syn_q   <= out_syn_d;
            out_err_q   <= out_err_d;
            abort_q     <= abort_d;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_q;
    assign out_syn   = out_syn_q;
    assign out_err   = out_err_q;
    assign abort     = abort_q;

endmodule
